// File: rtl/mem_req_sched_pkg.sv
// Shared definitions for the dual-slot data-memory request scheduler:
// FSM state encoding and access-size codes.
package mem_req_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_req_slot.sv
// One MEM slot: latched request fields, pending-issue bit and the raw read
// word returned for it.
module mem_req_slot
    import mem_req_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              valid,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [DW/8-1:0]   wstrb,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    input  logic              clr_pend,
    input  logic              rd_we,
    input  logic [DW-1:0]     rd_data,
    output logic              pending,
    output logic              q_wr,
    output logic [1:0]        q_size,
    output logic [DW/8-1:0]   q_wstrb,
    output logic [AW-1:0]     q_addr,
    output logic [DW-1:0]     q_wdata,
    output logic [DW-1:0]     rdata
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= 1'b0;
            q_wr    <= 1'b0;
            q_size  <= 2'd0;
            q_wstrb <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
            rdata   <= '0;
        end else begin
            if (load) begin
                pending <= valid;
                q_wr    <= wr;
                q_size  <= size;
                q_wstrb <= wstrb;
                q_addr  <= addr;
                q_wdata <= wdata;
            end else if (clr_pend) begin
                pending <= 1'b0;
            end
            // A store's acknowledge carries no data, so its slot reads as zero.
            if (rd_we) begin
                rdata <= q_wr ? '0 : rd_data;
            end
        end
    end

endmodule

// File: rtl/mem_req_sched.sv
// Serialises the two MEM-slot accesses of a dual-issue pair onto a single
// req/addr_ok/data_ok data port, oldest slot first, one request outstanding.
module mem_req_sched
    import mem_req_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              start,
    input  logic              first_is_s2,
    input  logic              s1_valid,
    input  logic              s1_wr,
    input  logic [1:0]        s1_size,
    input  logic [DW/8-1:0]   s1_wstrb,
    input  logic [AW-1:0]     s1_addr,
    input  logic [DW-1:0]     s1_wdata,
    input  logic              s2_valid,
    input  logic              s2_wr,
    input  logic [1:0]        s2_size,
    input  logic [DW/8-1:0]   s2_wstrb,
    input  logic [AW-1:0]     s2_addr,
    input  logic [DW-1:0]     s2_wdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [DW/8-1:0]   data_wstrb,
    output logic [AW-1:0]     data_addr,
    output logic [DW-1:0]     data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DW-1:0]     data_rdata,
    output logic [DW-1:0]     s1_rdata,
    output logic [DW-1:0]     s2_rdata,
    output logic              done,
    output logic              stallreq
);

    state_t state;
    logic   cur_s2;
    logic   accept, issue_ok, resp_ok;
    logic   s1_pend, s2_pend;
    logic   s1_q_wr, s2_q_wr;
    logic [1:0]      s1_q_size, s2_q_size;
    logic [DW/8-1:0] s1_q_wstrb, s2_q_wstrb;
    logic [AW-1:0]   s1_q_addr, s2_q_addr;
    logic [DW-1:0]   s1_q_wdata, s2_q_wdata;

    always_comb begin
        accept   = (state == ST_IDLE) && start && (s1_valid || s2_valid) && !flush;
        issue_ok = (state == ST_REQ) && !flush && data_addr_ok;
        resp_ok  = (state == ST_WAIT) && data_data_ok && !flush;
    end

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk(clk), .resetn(resetn), .load(accept),
        .valid(s1_valid), .wr(s1_wr), .size(s1_size), .wstrb(s1_wstrb),
        .addr(s1_addr), .wdata(s1_wdata),
        .clr_pend(issue_ok && !cur_s2), .rd_we(resp_ok && !cur_s2), .rd_data(data_rdata),
        .pending(s1_pend), .q_wr(s1_q_wr), .q_size(s1_q_size), .q_wstrb(s1_q_wstrb),
        .q_addr(s1_q_addr), .q_wdata(s1_q_wdata), .rdata(s1_rdata)
    );

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot2 (
        .clk(clk), .resetn(resetn), .load(accept),
        .valid(s2_valid), .wr(s2_wr), .size(s2_size), .wstrb(s2_wstrb),
        .addr(s2_addr), .wdata(s2_wdata),
        .clr_pend(issue_ok && cur_s2), .rd_we(resp_ok && cur_s2), .rd_data(data_rdata),
        .pending(s2_pend), .q_wr(s2_q_wr), .q_size(s2_q_size), .q_wstrb(s2_q_wstrb),
        .q_addr(s2_q_addr), .q_wdata(s2_q_wdata), .rdata(s2_rdata)
    );

    // Port fields come from latched copies so they stay stable while addr_ok is withheld.
    always_comb begin
        data_req   = (state == ST_REQ) && !flush;
        data_wr    = cur_s2 ? s2_q_wr    : s1_q_wr;
        data_size  = cur_s2 ? s2_q_size  : s1_q_size;
        data_wstrb = cur_s2 ? s2_q_wstrb : s1_q_wstrb;
        data_addr  = cur_s2 ? s2_q_addr  : s1_q_addr;
        data_wdata = cur_s2 ? s2_q_wdata : s1_q_wdata;
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE: stallreq = accept;
            ST_DONE: stallreq = 1'b0;
            default: stallreq = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cur_s2 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_REQ;
                        cur_s2 <= first_is_s2 ? s2_valid : !s1_valid;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (data_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= ST_IDLE;
                        end else if (cur_s2 ? s1_pend : s2_pend) begin
                            cur_s2 <= !cur_s2;
                            state  <= ST_REQ;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (flush) begin
                        state <= ST_CANCEL;
                    end
                end
                // The bridge still owes a response; swallow it before going idle.
                ST_CANCEL: begin
                    if (data_data_ok) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_sched.sv
// Bench for mem_req_sched: table of pair transactions against a port responder
// with a request scoreboard, plus flush/reset/no-valid sequences.
module tb_mem_req_sched;
    import mem_req_sched_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0, start = 1'b0, first_is_s2 = 1'b0;
    logic        s1_valid = 1'b0, s1_wr = 1'b0, s2_valid = 1'b0, s2_wr = 1'b0;
    logic [1:0]  s1_size = 2'd0, s2_size = 2'd0;
    logic [3:0]  s1_wstrb = 4'd0, s2_wstrb = 4'd0;
    logic [31:0] s1_addr = '0, s1_wdata = '0, s2_addr = '0, s2_wdata = '0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [31:0] s1_rdata, s2_rdata;
    logic        done, stallreq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_s1 = '0;
    logic [70:0] sb_q[$];

    typedef struct {
        logic        fs2;
        logic        v1, w1; logic [1:0] sz1; logic [3:0] st1; logic [31:0] a1, d1;
        logic        v2, w2; logic [1:0] sz2; logic [3:0] st2; logic [31:0] a2, d2;
        logic [31:0] r0, r1;
        int          hold;
        logic [31:0] e1, e2;
        int          nreq, dcyc;
    } vec_t;

    vec_t vecs[6];

    mem_req_sched #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .start(start), .first_is_s2(first_is_s2),
        .s1_valid(s1_valid), .s1_wr(s1_wr), .s1_size(s1_size), .s1_wstrb(s1_wstrb),
        .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s2_valid(s2_valid), .s2_wr(s2_wr), .s2_size(s2_size), .s2_wstrb(s2_wstrb),
        .s2_addr(s2_addr), .s2_wdata(s2_wdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s1_rdata(s1_rdata), .s2_rdata(s2_rdata), .done(done), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_slots(input vec_t v);
        first_is_s2 = v.fs2;
        s1_valid = v.v1; s1_wr = v.w1; s1_size = v.sz1; s1_wstrb = v.st1; s1_addr = v.a1; s1_wdata = v.d1;
        s2_valid = v.v2; s2_wr = v.w2; s2_size = v.sz2; s2_wstrb = v.st2; s2_addr = v.a2; s2_wdata = v.d2;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int nreq, ndone, dcyc, hold;
        logic resp_due;
        v = vecs[i];
        sb_q.delete();
        if (v.fs2) begin
            if (v.v2) sb_q.push_back({v.w2, v.sz2, v.st2, v.a2, v.d2});
            if (v.v1) sb_q.push_back({v.w1, v.sz1, v.st1, v.a1, v.d1});
        end else begin
            if (v.v1) sb_q.push_back({v.w1, v.sz1, v.st1, v.a1, v.d1});
            if (v.v2) sb_q.push_back({v.w2, v.sz2, v.st2, v.a2, v.d2});
        end
        nreq = 0; ndone = 0; dcyc = -1; hold = v.hold; resp_due = 1'b0;
        for (int cyc = 0; cyc < 40 && ndone == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) drive_slots(v);
            start = (cyc == 0);
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata = '0;
            if (resp_due) begin
                data_data_ok = 1'b1;
                data_rdata = (nreq == 1) ? v.r0 : v.r1;
                resp_due = 1'b0;
            end
            #1;
            if (done) begin
                ndone++;
                dcyc = cyc;
                check($sformatf("v%0d_stall_at_done", i), stallreq, 1'b0);
            end else begin
                check($sformatf("v%0d_stall_c%0d", i, cyc), stallreq, 1'b1);
            end
            if (data_req) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL v%0d_extra_req: got request at addr %0h, expected none", i, data_addr);
                end else begin
                    check($sformatf("v%0d_req_fields", i),
                          {data_wr, data_size, data_wstrb, data_addr, data_wdata}, sb_q[0]);
                    if (hold > 0) begin
                        hold--;
                    end else begin
                        data_addr_ok = 1'b1;
                        void'(sb_q.pop_front());
                        nreq++;
                        resp_due = 1'b1;
                    end
                end
            end
        end
        check($sformatf("v%0d_nreq", i), nreq, v.nreq);
        check($sformatf("v%0d_ndone", i), ndone, 1);
        check($sformatf("v%0d_done_cyc", i), dcyc, v.dcyc);
        if (v.v1) begin
            check($sformatf("v%0d_s1_rdata", i), s1_rdata, v.e1);
            last_s1 = v.e1;
        end
        if (v.v2) check($sformatf("v%0d_s2_rdata", i), s2_rdata, v.e2);
        @(negedge clk);
        start = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check($sformatf("v%0d_done_pulse", i), done, 1'b0);
        check($sformatf("v%0d_idle_stall", i), stallreq, 1'b0);
    endtask

    initial begin
        //          fs2   v1  w1  sz1     st1   a1            d1            v2  w2  sz2     st2   a2            d2            r0            r1            hold e1            e2            nreq dcyc
        vecs[0] = '{1'b0, 1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_1004, 32'h0,        1'b0, 1'b0, SIZE_W, 4'h0, 32'h0,         32'h0,        32'hDEAD_BEEF, 32'h0,        0, 32'hDEAD_BEEF, 32'h0,        1, 3};
        vecs[1] = '{1'b1, 1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_0020, 32'h0,        1'b1, 1'b1, SIZE_W, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'hAAAA_5555, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 32'h0,        2, 5};
        vecs[2] = '{1'b0, 1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_0040, 32'h0,        1'b0, 1'b0, SIZE_W, 4'h0, 32'h0,         32'h0,        32'h0102_0304, 32'h0,        3, 32'h0102_0304, 32'h0,        1, 6};
        vecs[3] = '{1'b0, 1'b1, 1'b0, SIZE_B, 4'h1, 32'h0000_0100, 32'h0,        1'b1, 1'b0, SIZE_H, 4'h3, 32'h0000_0104, 32'h0,        32'h0000_0011, 32'h0000_2222, 0, 32'h0000_0011, 32'h0000_2222, 2, 5};
        vecs[4] = '{1'b0, 1'b0, 1'b0, SIZE_W, 4'h0, 32'h0,         32'h0,        1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_0200, 32'h0,        32'h55AA_55AA, 32'h0,        0, 32'h0,        32'h55AA_55AA, 1, 3};
        vecs[5] = '{1'b0, 1'b1, 1'b1, SIZE_H, 4'h3, 32'h0000_0300, 32'h0000_BEEF, 1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_0304, 32'h0,        32'hFFFF_FFFF, 32'h0000_0077, 0, 32'h0,        32'h0000_0077, 2, 5};

        repeat (3) @(negedge clk);
        #1;
        check("rst_data_req", data_req, 1'b0);
        check("rst_stallreq", stallreq, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fields", {data_wr, data_size, data_wstrb, data_addr, data_wdata}, 71'd0);
        check("rst_rdata", {s1_rdata, s2_rdata}, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // flush while waiting for data: response must be swallowed
        @(negedge clk);
        s1_valid = 1'b1; s1_wr = 1'b0; s1_addr = 32'h80; s2_valid = 1'b0; first_is_s2 = 1'b0; start = 1'b1;
        #1; check("fw_start_stall", stallreq, 1'b1);
        @(negedge clk); start = 1'b0;
        #1; check("fw_req", data_req, 1'b1);
        data_addr_ok = 1'b1;
        @(negedge clk); data_addr_ok = 1'b0; flush = 1'b1;
        #1; check("fw_wait_noreq", data_req, 1'b0); check("fw_wait_stall", stallreq, 1'b1);
        @(negedge clk); flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        #1; check("fw_cancel_noreq", data_req, 1'b0); check("fw_cancel_stall", stallreq, 1'b1);
        check("fw_cancel_done", done, 1'b0);
        @(negedge clk); data_data_ok = 1'b0;
        #1; check("fw_idle_stall", stallreq, 1'b0); check("fw_idle_done", done, 1'b0);
        check("fw_idle_req", data_req, 1'b0); check("fw_s1_kept", s1_rdata, last_s1);

        // flush in REQ before addr_ok: request withdrawn in the same cycle
        @(negedge clk);
        s1_valid = 1'b0; s2_valid = 1'b1; s2_wr = 1'b0; s2_addr = 32'h400; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1; check("fr_req", data_req, 1'b1);
        @(negedge clk); flush = 1'b1;
        #1; check("fr_req_drop", data_req, 1'b0);
        @(negedge clk); flush = 1'b0;
        #1; check("fr_idle_stall", stallreq, 1'b0); check("fr_idle_req", data_req, 1'b0);

        // flush overrides start in IDLE
        @(negedge clk); start = 1'b1; flush = 1'b1;
        #1; check("fs_stall", stallreq, 1'b0);
        @(negedge clk); start = 1'b0; flush = 1'b0;
        #1; check("fs_noreq", data_req, 1'b0);

        // start with no valid slot
        @(negedge clk); s1_valid = 1'b0; s2_valid = 1'b0; start = 1'b1;
        #1; check("nv_stall", stallreq, 1'b0);
        @(negedge clk); start = 1'b0;
        #1; check("nv_req", data_req, 1'b0); check("nv_stall2", stallreq, 1'b0); check("nv_done", done, 1'b0);

        // reset in WAIT: straight back to IDLE with cleared outputs
        @(negedge clk);
        s1_valid = 1'b1; s1_wr = 1'b0; s1_addr = 32'h0000_1004; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1; check("rw_req", data_req, 1'b1);
        data_addr_ok = 1'b1;
        @(negedge clk); data_addr_ok = 1'b0; resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        #1; check("rw_req0", data_req, 1'b0); check("rw_stall0", stallreq, 1'b0);
        check("rw_done0", done, 1'b0); check("rw_addr0", data_addr, 32'h0);
        check("rw_rdata0", {s1_rdata, s2_rdata}, 64'd0);
        s1_valid = 1'b0;

        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
